zap_div32: RTL and testbench
============================

Name: zap_div32

Overview:
- Iterative radix-2 restoring divider, signed and unsigned. It is the inverse companion of the single-cycle 17x17 signed multiplier in the ALU shift/multiply path.
- Accepts one division per start pulse and produces the quotient and remainder after a fixed WIDTH+2 cycles.
- Used by the execute stage for divide/modulo micro-ops; the stage stalls while o_busy is high.

Parameters:
WIDTH, 32, operand/result width in bits (must be >=2)

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous reset, active-high
i_clear  input  1  synchronous abort (pipeline flush); returns to IDLE
i_start  input  1  start request; accepted only in IDLE
i_signed  input  1  1 = two's-complement operands, 0 = unsigned
i_dividend  input  WIDTH  dividend, sampled at accept
i_divisor  input  WIDTH  divisor, sampled at accept
o_busy  output  1  high while a division is in progress
o_done  output  1  one-cycle pulse; results valid in this cycle
o_quotient  output  WIDTH  quotient, held until the next o_done
o_remainder  output  WIDTH  remainder, held until the next o_done
o_div_by_zero  output  1  divisor was zero for the result currently presented

Behaviour:
- Reset (async, i_reset=1): state=IDLE; o_busy, o_done, o_div_by_zero = 0; o_quotient, o_remainder = 0; internal registers = 0.
- States:
  - IDLE: on i_start && !i_clear, latch operands and mode, go to CALC with counter = WIDTH-1.
  - CALC: one restoring step per cycle.
    - Shift the {rem, quo} pair left by 1.
    - Trial-subtract the divisor magnitude from rem using a WIDTH+1-bit subtractor.
    - If the difference is non-negative, rem = difference and quo LSB = 1; otherwise quo LSB = 0.
    - After WIDTH steps, go to FIX.
  - FIX: apply sign correction and divide-by-zero override, register the outputs, assert o_done, return to IDLE.
- Timing: accept at edge 0; o_busy high from edge 0 through the FIX cycle; o_done high for exactly one cycle, WIDTH+2 cycles after accept. For WIDTH=32, accept at edge 0 puts o_done high after edge 34.
- Back-to-back: i_start may be asserted in the same cycle o_done is high. The FSM is in IDLE on the next edge, so a new start is accepted then.
- i_start while busy: ignored, not queued.
- Signed mode:
  - Operand magnitudes are taken at accept.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend (truncating division).
- Overflow: (-2^(WIDTH-1)) / -1 gives quotient = 0x8000_0000 and remainder = 0. No flag is raised.
- Divide by zero:
  - Full latency is kept.
  - Quotient = all ones, in both modes.
  - Remainder = the original dividend, unmodified.
  - o_div_by_zero = 1.
- o_div_by_zero updates only at o_done; otherwise it holds.
- i_clear:
  - Highest priority: forces IDLE on the next edge with o_busy=0 and no o_done; results are unchanged.
  - If i_clear and i_start are asserted together, i_clear wins and the start is dropped.
  - If i_clear arrives in the FIX cycle, it suppresses o_done and the output update.
- Async reset mid-operation aborts immediately; outputs return to their reset values.
- Operand inputs may change freely after accept; only the latched copies are used.

Decomposition:
- Package zap_div_pkg holds:
  - state encoding localparams: IDLE=2'd0, CALC=2'd1, FIX=2'd2;
  - a function abs_val(value, signed_mode);
  - a function neg_if(value, condition).
- Sub-module zap_div_step: a purely combinational single restoring step.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Instantiated once inside the FSM.

Test Plan:
- Unsigned 100/7, i_signed=0 -> o_done 34 cycles after accept; quotient=14, remainder=2, o_div_by_zero=0.
- Signed -100/7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); then 100/-7 -> quotient=-14, remainder=2.
- 0x12345678/0, in both modes -> quotient=0xFFFFFFFF, remainder=0x12345678, o_div_by_zero=1; the next valid divide clears the flag.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- i_start pulsed at cycle 10 mid-divide -> ignored; i_clear at cycle 20 -> o_busy low at the next edge, no o_done, previous results held; i_start together with i_clear -> not accepted.
- Back-to-back: second i_start in the o_done cycle -> accepted, second o_done 34 cycles later; async i_reset mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/zap_div_pkg.sv
// Shared definitions for the zap_div32 iterative divider.
//   - State encoding for the divider FSM.
//   - abs_val / neg_if helpers. They work on a MaxWidth-bit container, so any
//     divider width below MaxWidth can use them. Callers sign-extend signed
//     values into the container and truncate the result back with a width cast.
package zap_div_pkg;

  localparam int unsigned MaxWidth = 64;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StCalc = CALC,
    StFix  = FIX
  } state_e;

  typedef logic [MaxWidth-1:0] wide_t;

  // Magnitude of a value that has already been sign-extended to MaxWidth.
  function automatic wide_t abs_val(input wide_t value, input logic signed_mode);
    return (signed_mode && value[MaxWidth-1]) ? -value : value;
  endfunction

  // Two's-complement negation when condition is set.
  function automatic wide_t neg_if(input wide_t value, input logic condition);
    return condition ? -value : value;
  endfunction

endpackage

// File: rtl/zap_div_step.sv
// One combinational radix-2 restoring division step.
// Ports:
//   rem      - partial remainder (always below divisor for a nonzero divisor)
//   quo      - dividend bits still to be consumed / quotient bits produced so far
//   divisor  - divisor magnitude
//   rem_next - remainder after this step
//   quo_next - quotient/dividend register after this step
module zap_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // Shift {rem, quo} left by one; the bit leaving rem is kept in shifted[WIDTH].
    shifted = {rem, quo[WIDTH-1]};
    // shifted < 2*divisor, so diff[WIDTH] is a reliable sign bit.
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
    end else begin
      rem_next = diff[WIDTH-1:0];
    end
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/zap_div32.sv
// Iterative radix-2 restoring divider, signed or unsigned.
// One division per accepted start; results appear WIDTH+2 cycles after accept.
// Ports:
//   i_clk, i_reset      - clock (rising edge), asynchronous active-high reset
//   i_clear             - synchronous abort, highest priority, returns to idle
//   i_start, i_signed   - start request (idle only) and two's-complement mode
//   i_dividend/divisor  - operands, sampled at accept
//   o_busy              - division in progress
//   o_done              - one-cycle pulse, results valid
//   o_quotient/remainder- results, held until the next o_done
//   o_div_by_zero       - divisor of the presented result was zero
// WIDTH must lie in [2, MaxWidth-1].
module zap_div32
  import zap_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  // One extra bit so the counter wraps negative once all WIDTH steps are done.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  dsr_q;
  logic [WIDTH-1:0]  dvd_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  quotient_q;
  logic [WIDTH-1:0]  remainder_q;
  logic              dbz_q;

  logic [WIDTH-1:0]  rem_nx;
  logic [WIDTH-1:0]  quo_nx;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dsr_mag;
  logic [WIDTH-1:0]  quo_fix;
  logic [WIDTH-1:0]  rem_fix;
  logic              dvd_neg;
  logic              dsr_neg;
  logic              dsr_zero;

  function automatic wide_t widen(input logic [WIDTH-1:0] v, input logic sext);
    return {{(MaxWidth-WIDTH){sext & v[WIDTH-1]}}, v};
  endfunction

  always_comb begin
    dvd_neg  = i_signed & i_dividend[WIDTH-1];
    dsr_neg  = i_signed & i_divisor[WIDTH-1];
    dvd_mag  = WIDTH'(abs_val(widen(i_dividend, i_signed), i_signed));
    dsr_mag  = WIDTH'(abs_val(widen(i_divisor, i_signed), i_signed));
    quo_fix  = WIDTH'(neg_if(widen(quo_q, 1'b0), neg_quo_q));
    rem_fix  = WIDTH'(neg_if(widen(rem_q, 1'b0), neg_rem_q));
    dsr_zero = (dsr_q == '0);
  end

  zap_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dsr_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_clear) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_start) begin
              state_q   <= StCalc;
              busy_q    <= 1'b1;
              cnt_q     <= CntW'(WIDTH - 1);
              rem_q     <= '0;
              quo_q     <= dvd_mag;
              dsr_q     <= dsr_mag;
              dvd_q     <= i_dividend;
              neg_quo_q <= dvd_neg ^ dsr_neg;
              neg_rem_q <= dvd_neg;
            end
          end
          StCalc: begin
            // The cycle after the last step is spent here too, which gives the
            // fixed WIDTH+2 accept-to-done latency.
            if (cnt_q[CntW-1]) begin
              state_q <= StFix;
            end else begin
              rem_q <= rem_nx;
              quo_q <= quo_nx;
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StFix: begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            dbz_q       <= dsr_zero;
            quotient_q  <= dsr_zero ? '1 : quo_fix;
            remainder_q <= dsr_zero ? dvd_q : rem_fix;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_quotient    = quotient_q;
  assign o_remainder   = remainder_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_zap_div32.sv
// Directed self-checking bench for zap_div32 (WIDTH = 32).
module tb_zap_div32;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_start = 1'b0;
  logic        i_signed = 1'b0;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_div_by_zero;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int ndone;

  zap_div32 #(
    .WIDTH (32)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (i_clear),
    .i_start       (i_start),
    .i_signed      (i_signed),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents operands with a one-cycle start pulse; returns #1 after the accept edge.
  task automatic start_div(input logic sgn, input logic [31:0] dvd, input logic [31:0] dsr);
    @(negedge i_clk);
    i_signed   = sgn;
    i_dividend = dvd;
    i_divisor  = dsr;
    i_start    = 1'b1;
    @(posedge i_clk);
    #1;
    i_start    = 1'b0;
    i_dividend = 32'hDEAD_BEEF;
    i_divisor  = 32'h0000_0003;
  endtask

  // Edges counted from the accept edge until o_done is seen; -1 if it never comes.
  task automatic wait_done(output int latency);
    latency = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge i_clk);
      #1;
      if (o_done) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge i_clk);
      #1;
      if (o_done) n++;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] dvd,
                         input logic [31:0] dsr, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input logic exp_dbz);
    int l;
    start_div(sgn, dvd, dsr);
    wait_done(l);
    chk({tag, " latency"}, l, 34);
    chk({tag, " quotient"}, o_quotient, exp_q);
    chk({tag, " remainder"}, o_remainder, exp_r);
    chk({tag, " dbz"}, {31'b0, o_div_by_zero}, {31'b0, exp_dbz});
    chk({tag, " busy at done"}, {31'b0, o_busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst busy", {31'b0, o_busy}, 32'd0);
    chk("rst done", {31'b0, o_done}, 32'd0);
    chk("rst quotient", o_quotient, 32'd0);
    chk("rst remainder", o_remainder, 32'd0);
    chk("rst dbz", {31'b0, o_div_by_zero}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    run_div("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("s -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_div("s 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
    run_div("s -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
    run_div("u dbz", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_div("s dbz", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_div("u after dbz", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("s overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_div("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_div("u max/max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);

    // Start pulsed mid-divide is ignored and not queued
    start_div(1'b0, 32'd200, 32'd10);
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_dividend = 32'd9;
    i_divisor  = 32'd3;
    i_start    = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done(lat);
    chk("ignored start latency", lat, 24);
    chk("ignored start quotient", o_quotient, 32'd20);
    chk("ignored start remainder", o_remainder, 32'd0);
    count_done(40, ndone);
    chk("ignored start not queued", ndone, 0);

    // Clear mid-divide
    start_div(1'b0, 32'd1000, 32'd3);
    repeat (19) @(posedge i_clk);
    @(negedge i_clk);
    i_clear = 1'b1;
    @(posedge i_clk);
    #1;
    i_clear = 1'b0;
    chk("clear busy", {31'b0, o_busy}, 32'd0);
    count_done(40, ndone);
    chk("clear no done", ndone, 0);
    chk("clear quotient held", o_quotient, 32'd20);
    chk("clear remainder held", o_remainder, 32'd0);

    // Start together with clear is dropped
    @(negedge i_clk);
    i_dividend = 32'd77;
    i_divisor  = 32'd7;
    i_start    = 1'b1;
    i_clear    = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_clear = 1'b0;
    chk("start+clear busy", {31'b0, o_busy}, 32'd0);
    count_done(40, ndone);
    chk("start+clear no done", ndone, 0);
    chk("start+clear quotient held", o_quotient, 32'd20);

    // Back-to-back: new start in the o_done cycle
    start_div(1'b0, 32'd100, 32'd7);
    wait_done(lat);
    chk("b2b first latency", lat, 34);
    chk("b2b first quotient", o_quotient, 32'd14);
    i_signed   = 1'b0;
    i_dividend = 32'd50;
    i_divisor  = 32'd5;
    i_start    = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    chk("b2b done single pulse", {31'b0, o_done}, 32'd0);
    chk("b2b second busy", {31'b0, o_busy}, 32'd1);
    wait_done(lat);
    chk("b2b second latency", lat, 34);
    chk("b2b second quotient", o_quotient, 32'd10);
    chk("b2b second remainder", o_remainder, 32'd0);

    // Async reset mid-CALC
    start_div(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge i_clk);
    #3;
    i_reset = 1'b1;
    #1;
    chk("areset busy", {31'b0, o_busy}, 32'd0);
    chk("areset quotient", o_quotient, 32'd0);
    chk("areset remainder", o_remainder, 32'd0);
    chk("areset dbz", {31'b0, o_div_by_zero}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    run_div("s -7/2 after reset", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
            1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
